router_dor: RTL and testbench

ROUTER_DOR -- requirements
Module: router_dor

---
 rtl/router_dor.sv | 197 +++++++++++++++++++
 tb/tb_router_dor.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/router_dor.sv
// router_dor: 7-port dimension-order (X, Y, Z) router with per-input FIFOs,
// per-output round-robin arbiters and registered outputs.
// Port index: 0=inject/eject, 1=XPOS, 2=YPOS, 3=ZPOS, 4=XNEG, 5=YNEG, 6=ZNEG.
// Optional macro ROUTER_TORUS_EN: shortest-path torus routing with DIM_SIZE
// wrap. Without it, plain mesh routing is used and DIM_SIZE is ignored.

module router_dor_fifo #(
   parameter int W     = 82,
   parameter int DEPTH = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         empty,
   output logic         full
);
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNTW = $clog2(DEPTH + 1);

   logic [W-1:0]    mem [DEPTH];
   logic [PW-1:0]   wp, rp;
   logic [CNTW-1:0] cnt;

   function automatic logic [PW-1:0] bump(logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // storage array, not reset: contents are only visible through cnt
   always_ff @(posedge clk) begin
      if (wr_en) mem[wp] <= wr_data;
   end

   // pointers and occupancy; reset drops every queued flit
   always_ff @(posedge clk) begin
      if (!rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (wr_en) wp <= bump(wp);
         if (rd_en) rp <= bump(rp);
         case ({wr_en, rd_en})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign rd_data = mem[rp];
   assign empty   = (cnt == '0);
   assign full    = (cnt == CNTW'(DEPTH));
endmodule

module router_dor #(
   parameter int FLIT_SIZE = 82,
   parameter int CW        = 4,
   parameter int Q_DEPTH   = 5,
   parameter int cur_x     = 0,
   parameter int cur_y     = 0,
   parameter int cur_z     = 0,
   parameter int DIM_SIZE  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7*FLIT_SIZE-1:0] in_flit,
   input  logic [6:0]             in_valid,
   output logic [6:0]             in_ready,
   output logic [7*FLIT_SIZE-1:0] out_flit,
   output logic [6:0]             out_valid,
   input  logic [6:0]             out_ready
);
   localparam int NP = 7;
   localparam logic [CW-1:0] CX = CW'(cur_x);
   localparam logic [CW-1:0] CY = CW'(cur_y);
   localparam logic [CW-1:0] CZ = CW'(cur_z);

   localparam logic [2:0] P_EJECT = 3'd0;
   localparam logic [2:0] P_XPOS  = 3'd1;
   localparam logic [2:0] P_YPOS  = 3'd2;
   localparam logic [2:0] P_ZPOS  = 3'd3;
   localparam logic [2:0] P_XNEG  = 3'd4;
   localparam logic [2:0] P_YNEG  = 3'd5;
   localparam logic [2:0] P_ZNEG  = 3'd6;

   logic [NP-1:0][FLIT_SIZE-1:0] head;
   logic [NP-1:0][FLIT_SIZE-1:0] oflit;
   logic [NP-1:0][2:0]           route_sel;
   logic [NP-1:0][NP-1:0]        req;        // req[input][output]
   logic [NP-1:0][2:0]           ptr;
   logic [NP-1:0][2:0]           gnt_idx;
   logic [NP-1:0]                gnt_vld;
   logic [NP-1:0]                pop;
   logic [NP-1:0]                empty;
   logic [NP-1:0]                full;

   // one dimension step; caller guarantees dst != cur
   function automatic logic [2:0] step(logic [CW-1:0] dst, logic [CW-1:0] cur,
                                       logic [2:0] pos, logic [2:0] neg);
`ifdef ROUTER_TORUS_EN
      int d;
      d = ((int'(dst) - int'(cur)) % DIM_SIZE + DIM_SIZE) % DIM_SIZE;
      return (d <= DIM_SIZE / 2) ? pos : neg;   // ties go POS
`else
      return (dst > cur) ? pos : neg;
`endif
   endfunction

   // X first, then Y, then Z; fully matched coordinates eject
   function automatic logic [2:0] route(logic [FLIT_SIZE-1:0] f);
      logic [CW-1:0] dx, dy, dz;
      dx = f[FLIT_SIZE-2 -: CW];
      dy = f[FLIT_SIZE-2-CW -: CW];
      dz = f[FLIT_SIZE-2-2*CW -: CW];
      if (dx != CX)      return step(dx, CX, P_XPOS, P_XNEG);
      else if (dy != CY) return step(dy, CY, P_YPOS, P_YNEG);
      else if (dz != CZ) return step(dz, CZ, P_ZPOS, P_ZNEG);
      else               return P_EJECT;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < NP; gi++) begin : g_in
         // in_ready is held low during reset and whenever the queue is full
         assign in_ready[gi] = rst && !full[gi];

         router_dor_fifo #(.W(FLIT_SIZE), .DEPTH(Q_DEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (in_valid[gi] && in_ready[gi]),
            .wr_data (in_flit[gi*FLIT_SIZE +: FLIT_SIZE]),
            .rd_en   (pop[gi]),
            .rd_data (head[gi]),
            .empty   (empty[gi]),
            .full    (full[gi])
         );

         assign route_sel[gi] = route(head[gi]);
         assign out_flit[gi*FLIT_SIZE +: FLIT_SIZE] = oflit[gi];
      end
   endgenerate

   // request matrix: each non-empty head asks for exactly one output
   always_comb begin
      req = '0;
      for (int i = 0; i < NP; i++)
         if (!empty[i]) req[i][route_sel[i]] = 1'b1;
   end

   // round-robin arbitration per eligible output, starting at ptr[o]
   always_comb begin
      int idx;
      idx     = 0;
      gnt_vld = '0;
      gnt_idx = '0;
      for (int o = 0; o < NP; o++) begin
         if (!out_valid[o] || out_ready[o]) begin
            for (int k = 0; k < NP; k++) begin
               idx = (int'(ptr[o]) + k) % NP;
               if (!gnt_vld[o] && req[idx][o]) begin
                  gnt_vld[o] = 1'b1;
                  gnt_idx[o] = 3'(idx);
               end
            end
         end
      end
   end

   // granted heads pop; an input requests one output so pops never collide
   always_comb begin
      pop = '0;
      for (int o = 0; o < NP; o++)
         if (gnt_vld[o]) pop[gnt_idx[o]] = 1'b1;
   end

   // output registers and arbiter pointers; data holds while stalled
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid <= '0;
         oflit     <= '0;
         ptr       <= '0;
      end else begin
         for (int o = 0; o < NP; o++) begin
            if (gnt_vld[o]) begin
               oflit[o]     <= head[gnt_idx[o]];
               out_valid[o] <= 1'b1;
               ptr[o]       <= (gnt_idx[o] == 3'd6) ? 3'd0 : gnt_idx[o] + 3'd1;
            end else if (out_ready[o]) begin
               out_valid[o] <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_router_dor.sv
// Directed testbench for router_dor at cur=(0,0,0), default parameters.
module tb_router_dor;
   localparam int F = 82;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [7*F-1:0] in_flit = '0;
   logic [6:0]     in_valid = '0;
   logic [6:0]     in_ready;
   logic [7*F-1:0] out_flit;
   logic [6:0]     out_valid;
   logic [6:0]     out_ready = 7'h7f;

   int errors = 0;
   int checks = 0;

   router_dor dut (
      .clk       (clk),
      .rst       (rst),
      .in_flit   (in_flit),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_flit  (out_flit),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [F-1:0] mk(int x, int y, int z, logic [31:0] pl);
      logic [F-1:0] f;
      f = '0;
      f[F-1] = 1'b1;
      f[F-2 -: 4]  = 4'(x);
      f[F-6 -: 4]  = 4'(y);
      f[F-10 -: 4] = 4'(z);
      f[31:0] = pl;
      return f;
   endfunction

   function automatic logic [F-1:0] oslice(int o);
      return out_flit[o*F +: F];
   endfunction

   task automatic set_in(int p, logic [F-1:0] f);
      in_flit[p*F +: F] = f;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int acc;
      logic [F-1:0] a, b;
      logic [6:0] exp_mask;
      int exp_o0;

      // reset state
      rst = 1'b0;
      tick(); tick();
      chk("reset_out_valid", 128'(out_valid), 128'(0));
      chk("reset_out_flit_zero", 128'(|out_flit), 128'(0));
      chk("reset_in_ready", 128'(in_ready), 128'(0));
      rst = 1'b1;
      #1;
      chk("release_in_ready", 128'(in_ready), 128'(7'h7f));

      // local inject/eject, latency 2
      a = mk(0, 0, 0, 32'hDEAD0001);
      set_in(0, a); in_valid = 7'b0000001;
      tick();
      in_valid = '0;
      chk("eject_not_early", 128'(out_valid), 128'(0));
      tick();
      chk("eject_valid", 128'(out_valid), 128'(7'b0000001));
      chk("eject_payload", 128'(oslice(0)), 128'(a));
      tick();
      chk("eject_clears", 128'(out_valid), 128'(0));

      // concurrent XPOS and YPOS
      a = mk(2, 1, 0, 32'hA1);
      b = mk(0, 3, 0, 32'hB2);
      set_in(1, a); set_in(2, b); in_valid = 7'b0000110;
      tick();
      in_valid = '0;
      tick();
      chk("xy_valid", 128'(out_valid), 128'(7'b0000110));
      chk("xpos_payload", 128'(oslice(1)), 128'(a));
      chk("ypos_payload", 128'(oslice(2)), 128'(b));
      tick();

      // three inputs to ZPOS, two flits each -> grants rotate 0,1,2,0,1,2
      for (int s = 0; s < 3; s++) set_in(s, mk(0, 0, 1, 32'(s*16)));
      in_valid = 7'b0000111;
      tick();
      for (int s = 0; s < 3; s++) set_in(s, mk(0, 0, 1, 32'(s*16 + 1)));
      tick();
      in_valid = '0;
      for (int n = 0; n < 6; n++) begin
         chk("rr_valid", 128'(out_valid[3]), 128'(1));
         chk("rr_order", 128'(oslice(3)), 128'(mk(0, 0, 1, 32'((n % 3)*16 + n / 3))));
         tick();
      end
      chk("rr_drained", 128'(out_valid), 128'(0));

      // backpressure on XPOS with continuous input 1 traffic
      out_ready[1] = 1'b0;
      acc = 0;
      for (int c = 0; c < 20; c++) begin
         logic rdy;
         set_in(1, mk(1, 0, 0, 32'(32'h100 + acc)));
         in_valid = 7'b0000010;
         rdy = in_ready[1];
         tick();
         if (rdy) acc++;
         if (c == 10) chk("bp_hold_mid", 128'(oslice(1)), 128'(mk(1, 0, 0, 32'h100)));
      end
      in_valid = '0;
      chk("bp_accepts", 128'(acc), 128'(6));
      chk("bp_in_ready_low", 128'(in_ready[1]), 128'(0));
      chk("bp_out_valid", 128'(out_valid[1]), 128'(1));
      chk("bp_hold_end", 128'(oslice(1)), 128'(mk(1, 0, 0, 32'h100)));
      out_ready[1] = 1'b1;
      for (int k = 1; k < 6; k++) begin
         tick();
         chk("bp_drain", 128'(oslice(1)), 128'(mk(1, 0, 0, 32'(32'h100 + k))));
      end
      tick();
      chk("bp_drain_done", 128'(out_valid), 128'(0));
      chk("bp_in_ready_back", 128'(in_ready), 128'(7'h7f));

      // routing: dst_x=3 (mesh XPOS / torus XNEG) and Y-before-Z
      set_in(0, mk(3, 0, 0, 32'hC0));
      set_in(4, mk(0, 2, 3, 32'hC4));
      in_valid = 7'b0010001;
      tick();
      in_valid = '0;
      tick();
`ifdef ROUTER_TORUS_EN
      exp_o0 = 4;
      exp_mask = 7'b0010100;
`else
      exp_o0 = 1;
      exp_mask = 7'b0000110;
`endif
      chk("route_mask", 128'(out_valid), 128'(exp_mask));
      chk("route_x3", 128'(oslice(exp_o0)), 128'(mk(3, 0, 0, 32'hC0)));
      chk("route_y_first", 128'(oslice(2)), 128'(mk(0, 2, 3, 32'hC4)));
      tick();

      // reset mid-operation with 3 flits queued behind a stalled output
      out_ready[1] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         set_in(1, mk(1, 0, 0, 32'(32'h200 + k)));
         in_valid = 7'b0000010;
         tick();
      end
      in_valid = '0;
      chk("pre_rst_valid", 128'(out_valid[1]), 128'(1));
      rst = 1'b0;
      tick();
      chk("mid_rst_valid", 128'(out_valid), 128'(0));
      chk("mid_rst_flit_zero", 128'(|out_flit), 128'(0));
      chk("mid_rst_in_ready", 128'(in_ready), 128'(0));
      rst = 1'b1;
      out_ready = 7'h7f;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("post_rst_no_old", 128'(out_valid), 128'(0));
      end
      a = mk(1, 0, 0, 32'h300);
      set_in(1, a); in_valid = 7'b0000010;
      tick();
      in_valid = '0;
      tick();
      chk("post_rst_fresh_valid", 128'(out_valid), 128'(7'b0000010));
      chk("post_rst_fresh_payload", 128'(oslice(1)), 128'(a));
      tick();
      chk("post_rst_idle", 128'(out_valid), 128'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
